sound_sequencer: RTL

- Control stage directly upstream of the audio sample player.
- Generates the 8 kHz sample strobe from the 25 MHz system clock.
- Arbitrates one-cycle game-event sound requests by priority and selects the active `sound_t`.
- Times each one-shot sound in sample strobes, then returns to silence. Issues a restart pulse on every sound start so the player can rewind its sample address.

---
 rtl/sound_sequencer.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/sound_sequencer.sv
// sound_sequencer: control stage ahead of the audio sample player.
// Derives the 8 kHz sample strobe from the 25 MHz clock, arbitrates one-cycle
// game-event requests by priority, times each one-shot sound in sample strobes
// and pulses sound_restart whenever a sound starts.
//
// Ports:
//   clk_25MHZ     in   system clock
//   rst           in   synchronous reset, active-high
//   req_intro     in   one-cycle request: intro  (priority 1)
//   req_chomp     in   one-cycle request: chomp  (priority 0)
//   req_death     in   one-cycle request: death  (priority 3)
//   req_win       in   one-cycle request: win    (priority 2)
//   mute          in   level; forces audio_en low, sequencing unaffected
//   clk_8KHZ      out  one-cycle sample strobe, period CLK_DIV
//   sound_type    out  selected sound (sound_t encoding below)
//   sound_restart out  one-cycle pulse on every sound start
//   audio_en      out  playing & ~mute
//   playing       out  high while in PLAY
//   done          out  one-cycle pulse on natural end of a sound
module sound_sequencer #(
  parameter int unsigned CLK_DIV   = 3125,
  parameter int unsigned INTRO_LEN = 12280,
  parameter int unsigned CHOMP_LEN = 5736,
  parameter int unsigned DEATH_LEN = 33736,
  parameter int unsigned WIN_LEN   = 16000
) (
  input  logic       clk_25MHZ,
  input  logic       rst,
  input  logic       req_intro,
  input  logic       req_chomp,
  input  logic       req_death,
  input  logic       req_win,
  input  logic       mute,
  output logic       clk_8KHZ,
  output logic [1:0] sound_type,
  output logic       sound_restart,
  output logic       audio_en,
  output logic       playing,
  output logic       done
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned CNT_W = 16;

  // sound_t encoding
  localparam logic [1:0] SOUND_LOADING   = 2'd0;
  localparam logic [1:0] SOUND_GAME_PLAY = 2'd1;
  localparam logic [1:0] SOUND_FAIL      = 2'd2;
  localparam logic [1:0] SOUND_WIN       = 2'd3;

  localparam logic [1:0] PRIO_CHOMP = 2'd0;
  localparam logic [1:0] PRIO_INTRO = 2'd1;
  localparam logic [1:0] PRIO_WIN   = 2'd2;
  localparam logic [1:0] PRIO_DEATH = 2'd3;

  typedef enum logic {IDLE, PLAY} state_t;

  state_t             state, state_d;
  logic [DIV_W-1:0]   div;
  logic [CNT_W-1:0]   sample_cnt, cnt_d;
  logic [CNT_W-1:0]   cur_len, len_d;
  logic [1:0]         cur_prio, prio_d;
  logic [1:0]         type_d;
  logic               restart_d;
  logic               done_d;
  logic               req_any_c;
  logic [1:0]         req_prio_c;

  function automatic logic [CNT_W-1:0] len_of(input logic [1:0] p);
    case (p)
      PRIO_DEATH: len_of = CNT_W'(DEATH_LEN);
      PRIO_WIN:   len_of = CNT_W'(WIN_LEN);
      PRIO_INTRO: len_of = CNT_W'(INTRO_LEN);
      default:    len_of = CNT_W'(CHOMP_LEN);
    endcase
  endfunction

  function automatic logic [1:0] type_of(input logic [1:0] p);
    case (p)
      PRIO_DEATH: type_of = SOUND_FAIL;
      PRIO_WIN:   type_of = SOUND_WIN;
      PRIO_INTRO: type_of = SOUND_LOADING;
      default:    type_of = SOUND_GAME_PLAY;
    endcase
  endfunction

  // Free-running strobe divider; only reset can realign it
  always_ff @(posedge clk_25MHZ) begin
    if (rst) begin
      div      <= '0;
      clk_8KHZ <= 1'b0;
    end else if (div == DIV_W'(CLK_DIV - 1)) begin
      div      <= '0;
      clk_8KHZ <= 1'b1;
    end else begin
      div      <= div + DIV_W'(1);
      clk_8KHZ <= 1'b0;
    end
  end

  // Highest-priority pending request; lower ones in the same cycle are dropped
  always_comb begin
    req_any_c  = req_death | req_win | req_intro | req_chomp;
    req_prio_c = PRIO_CHOMP;
    if (req_death)      req_prio_c = PRIO_DEATH;
    else if (req_win)   req_prio_c = PRIO_WIN;
    else if (req_intro) req_prio_c = PRIO_INTRO;
  end

  // Next-state: finish first, then evaluate a request against the
  // post-finish state so a request coinciding with the end always starts
  always_comb begin
    state_d   = state;
    cnt_d     = sample_cnt;
    prio_d    = cur_prio;
    len_d     = cur_len;
    type_d    = sound_type;
    restart_d = 1'b0;
    done_d    = 1'b0;

    if (state == PLAY && clk_8KHZ) begin
      if (sample_cnt == cur_len - CNT_W'(1)) begin
        state_d = IDLE;
        done_d  = 1'b1;
        cnt_d   = '0;
      end else begin
        cnt_d = sample_cnt + CNT_W'(1);
      end
    end

    // Chomp-on-chomp is the only equal-priority request that retriggers
    if (req_any_c && (state_d == IDLE || req_prio_c > cur_prio ||
                      (req_prio_c == PRIO_CHOMP && cur_prio == PRIO_CHOMP))) begin
      state_d   = PLAY;
      cnt_d     = '0;
      prio_d    = req_prio_c;
      len_d     = len_of(req_prio_c);
      type_d    = type_of(req_prio_c);
      restart_d = 1'b1;
    end
  end

  // State and registered outputs
  always_ff @(posedge clk_25MHZ) begin
    if (rst) begin
      state         <= IDLE;
      sample_cnt    <= '0;
      cur_prio      <= PRIO_CHOMP;
      cur_len       <= '0;
      sound_type    <= SOUND_LOADING;
      sound_restart <= 1'b0;
      done          <= 1'b0;
      playing       <= 1'b0;
      audio_en      <= 1'b0;
    end else begin
      state         <= state_d;
      sample_cnt    <= cnt_d;
      cur_prio      <= prio_d;
      cur_len       <= len_d;
      sound_type    <= type_d;
      sound_restart <= restart_d;
      done          <= done_d;
      playing       <= (state_d == PLAY);
      audio_en      <= (state_d == PLAY) & ~mute;
    end
  end

endmodule
